// File: rtl/alu_ex_mem_stage_if.sv
// EX->MEM pipeline-register bus: EX-side request with handshake, MEM-side registered entry,
// architectural NZCV flags and the forwarded B.cond outcome.
interface alu_ex_mem_stage_if #(parameter int CNT_W = 32);
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      alu_result;
  logic             alu_negative;
  logic             alu_zero;
  logic             alu_overflow;
  logic             alu_carry_out;
  logic             set_flags;
  logic [63:0]      store_data;
  logic [4:0]       rd;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic [3:0]       cond;
  logic             flush;
  logic             out_ready;
  logic             out_valid;
  logic [63:0]      out_result;
  logic [63:0]      out_store_data;
  logic [4:0]       out_rd;
  logic             out_mem_read;
  logic             out_mem_write;
  logic             out_reg_write;
  logic [3:0]       flags;
  logic             cond_true;
  logic [CNT_W-1:0] accept_count;

  modport master (
    output in_valid, alu_result, alu_negative, alu_zero, alu_overflow, alu_carry_out,
           set_flags, store_data, rd, mem_read, mem_write, reg_write, cond, flush, out_ready,
    input  in_ready, out_valid, out_result, out_store_data, out_rd, out_mem_read,
           out_mem_write, out_reg_write, flags, cond_true, accept_count
  );

  modport slave (
    input  in_valid, alu_result, alu_negative, alu_zero, alu_overflow, alu_carry_out,
           set_flags, store_data, rd, mem_read, mem_write, reg_write, cond, flush, out_ready,
    output in_ready, out_valid, out_result, out_store_data, out_rd, out_mem_read,
           out_mem_write, out_reg_write, flags, cond_true, accept_count
  );
endinterface

// File: rtl/alu_ex_mem_stage.sv
// Single-entry EX/MEM pipeline register with NZCV flag register, forwarded B.cond
// evaluation and a saturating accepted-instruction counter.
module alu_ex_mem_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_ex_mem_stage_if.slave bus
);
  typedef struct packed {
    logic [63:0] result;
    logic [63:0] store_data;
    logic [4:0]  rd;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
  } entry_t;

  entry_t           ent_q, ent_d;
  logic             vld_q;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             illegal_mem;
  logic [3:0]       fwd;
  logic             n, z, c, v;

  assign bus.in_ready = !vld_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready & !bus.flush;
  assign illegal_mem  = bus.mem_read & bus.mem_write;

  // Writes to XZR and read+write combinations are squashed before they reach MEM.
  always_comb begin
    ent_d            = '0;
    ent_d.result     = bus.alu_result;
    ent_d.store_data = bus.store_data;
    ent_d.rd         = bus.rd;
    ent_d.mem_read   = bus.mem_read & !illegal_mem;
    ent_d.mem_write  = bus.mem_write & !illegal_mem;
    ent_d.reg_write  = bus.reg_write & (bus.rd != 5'd31);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      ent_q   <= '0;
      flags_q <= 4'b0000;
      cnt_q   <= '0;
    end else if (bus.flush) begin
      vld_q <= 1'b0;
    end else if (accept) begin
      vld_q <= 1'b1;
      ent_q <= ent_d;
      if (bus.set_flags)
        flags_q <= {bus.alu_negative, bus.alu_zero, bus.alu_carry_out, bus.alu_overflow};
      if (cnt_q != '1)
        cnt_q <= cnt_q + CNT_W'(1);
    end else if (bus.out_ready) begin
      vld_q <= 1'b0;
    end
  end

  // A flag-setting instruction in EX overrides the architectural flags for B.cond.
  always_comb begin
    fwd = (bus.in_valid & bus.set_flags)
        ? {bus.alu_negative, bus.alu_zero, bus.alu_carry_out, bus.alu_overflow}
        : flags_q;
    n = fwd[3];
    z = fwd[2];
    c = fwd[1];
    v = fwd[0];
    case (bus.cond)
      4'h0:    bus.cond_true = z;
      4'h1:    bus.cond_true = !z;
      4'h2:    bus.cond_true = c;
      4'h3:    bus.cond_true = !c;
      4'h4:    bus.cond_true = n;
      4'h5:    bus.cond_true = !n;
      4'h6:    bus.cond_true = v;
      4'h7:    bus.cond_true = !v;
      4'h8:    bus.cond_true = c & !z;
      4'h9:    bus.cond_true = !c | z;
      4'hA:    bus.cond_true = (n == v);
      4'hB:    bus.cond_true = (n != v);
      4'hC:    bus.cond_true = !z & (n == v);
      4'hD:    bus.cond_true = z | (n != v);
      default: bus.cond_true = 1'b1;
    endcase
  end

  assign bus.out_valid      = vld_q;
  assign bus.out_result     = ent_q.result;
  assign bus.out_store_data = ent_q.store_data;
  assign bus.out_rd         = ent_q.rd;
  assign bus.out_mem_read   = ent_q.mem_read;
  assign bus.out_mem_write  = ent_q.mem_write;
  assign bus.out_reg_write  = ent_q.reg_write;
  assign bus.flags          = flags_q;
  assign bus.accept_count   = cnt_q;
endmodule

// File: tb/tb_alu_ex_mem_stage.sv
// Bench for alu_ex_mem_stage: directed vector table, handshake/reset sequences and
// randomized traffic against a cycle-level reference model.
module tb_alu_ex_mem_stage;
  logic clk;
  logic rst_n;
  logic rst4_n;

  alu_ex_mem_stage_if #(.CNT_W(32)) bus ();
  alu_ex_mem_stage_if #(.CNT_W(4))  bus4 ();

  alu_ex_mem_stage #(.CNT_W(32)) dut  (.clk(clk), .rst_n(rst_n),  .bus(bus));
  alu_ex_mem_stage #(.CNT_W(4))  dut4 (.clk(clk), .rst_n(rst4_n), .bus(bus4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int errs    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_valid;
  logic [63:0] m_res, m_sd;
  logic [4:0]  m_rd;
  logic        m_mr, m_mw, m_rw;
  logic [3:0]  m_flags;
  logic [31:0] m_cnt;

  function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
    logic nn, zz, cy, vv;
    {nn, zz, cy, vv} = f;
    case (cc)
      4'h0: return zz;            4'h1: return !zz;
      4'h2: return cy;            4'h3: return !cy;
      4'h4: return nn;            4'h5: return !nn;
      4'h6: return vv;            4'h7: return !vv;
      4'h8: return cy && !zz;     4'h9: return !cy || zz;
      4'hA: return nn == vv;      4'hB: return nn != vv;
      4'hC: return !zz && nn == vv;
      4'hD: return zz || nn != vv;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] alu_nzcv();
    return {bus.alu_negative, bus.alu_zero, bus.alu_carry_out, bus.alu_overflow};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_res = 0; m_sd = 0; m_rd = 0;
    m_mr = 0; m_mw = 0; m_rw = 0; m_flags = 0; m_cnt = 0;
  endtask

  function automatic logic m_ready();
    return !m_valid || bus.out_ready;
  endfunction

  task automatic model_edge();
    bit take;
    take = bus.in_valid && m_ready() && !bus.flush;
    if (bus.flush) m_valid = 0;
    else if (take) begin
      m_valid = 1;
      m_res   = bus.alu_result;
      m_sd    = bus.store_data;
      m_rd    = bus.rd;
      m_rw    = bus.reg_write && bus.rd != 31;
      m_mr    = bus.mem_read && !bus.mem_write;
      m_mw    = bus.mem_write && !bus.mem_read;
      if (bus.set_flags) m_flags = alu_nzcv();
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else if (bus.out_ready) m_valid = 0;
  endtask

  task automatic pre_edge();
    #1;
    chk("in_ready", 64'(bus.in_ready), 64'(m_ready()));
    chk("cond_true", 64'(bus.cond_true),
        64'(cond_ok(bus.cond, (bus.in_valid && bus.set_flags) ? alu_nzcv() : m_flags)));
    model_edge();
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
    chk("out_valid",      64'(bus.out_valid),     64'(m_valid));
    chk("out_result",     bus.out_result,         m_res);
    chk("out_store_data", bus.out_store_data,     m_sd);
    chk("out_rd",         64'(bus.out_rd),        64'(m_rd));
    chk("out_reg_write",  64'(bus.out_reg_write), 64'(m_rw));
    chk("out_mem_read",   64'(bus.out_mem_read),  64'(m_mr));
    chk("out_mem_write",  64'(bus.out_mem_write), 64'(m_mw));
    chk("flags",          64'(bus.flags),         64'(m_flags));
    chk("accept_count",   64'(bus.accept_count),  64'(m_cnt));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        iv, ordy, fl, sf;
    logic [3:0]  nzcv;
    logic [63:0] res;
    logic [4:0]  rd;
    logic        mr, mw, rw;
    logic [3:0]  cc;
    logic        e_ready, e_ct, e_valid;
    logic [63:0] e_res;
    logic [4:0]  e_rd;
    logic        e_rw, e_mr, e_mw;
    logic [3:0]  e_flags;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tab[9];

  function automatic vec_t mk(
    input logic iv, ordy, fl, sf, input logic [3:0] nzcv, input logic [63:0] res,
    input logic [4:0] rd, input logic mr, mw, rw, input logic [3:0] cc,
    input logic e_ready, e_ct, e_valid, input logic [63:0] e_res, input logic [4:0] e_rd,
    input logic e_rw, e_mr, e_mw, input logic [3:0] e_flags, input logic [31:0] e_cnt);
    vec_t t;
    t.iv = iv; t.ordy = ordy; t.fl = fl; t.sf = sf; t.nzcv = nzcv; t.res = res;
    t.rd = rd; t.mr = mr; t.mw = mw; t.rw = rw; t.cc = cc;
    t.e_ready = e_ready; t.e_ct = e_ct; t.e_valid = e_valid; t.e_res = e_res;
    t.e_rd = e_rd; t.e_rw = e_rw; t.e_mr = e_mr; t.e_mw = e_mw;
    t.e_flags = e_flags; t.e_cnt = e_cnt;
    return t;
  endfunction

  task automatic idle_inputs();
    bus.in_valid = 0; bus.alu_result = 0; bus.alu_negative = 0; bus.alu_zero = 0;
    bus.alu_overflow = 0; bus.alu_carry_out = 0; bus.set_flags = 0; bus.store_data = 0;
    bus.rd = 0; bus.mem_read = 0; bus.mem_write = 0; bus.reg_write = 0; bus.cond = 0;
    bus.flush = 0; bus.out_ready = 0;
  endtask

  initial begin
    //          iv ordy fl sf nzcv   res        rd mr mw rw cc    rdy ct vld e_res      e_rd rw mr mw flags    cnt
    tab[0] = mk(1, 1, 0, 0, 4'b0000, 64'h5,     3, 0, 0, 1, 4'h0, 1, 0, 1, 64'h5,     3,  1, 0, 0, 4'b0000, 1);
    tab[1] = mk(1, 1, 0, 1, 4'b0110, 64'h0,     9, 0, 0, 1, 4'h0, 1, 1, 1, 64'h0,     9,  1, 0, 0, 4'b0110, 2);
    tab[2] = mk(1, 1, 0, 0, 4'b0000, 64'hDEAD, 31, 1, 1, 1, 4'h8, 1, 0, 1, 64'hDEAD, 31,  0, 0, 0, 4'b0110, 3);
    tab[3] = mk(1, 1, 1, 1, 4'b1000, 64'h7,     4, 0, 0, 1, 4'h1, 1, 1, 0, 64'hDEAD, 31,  0, 0, 0, 4'b0110, 3);
    tab[4] = mk(0, 0, 0, 0, 4'b0000, 64'h0,     0, 0, 0, 0, 4'h2, 1, 1, 0, 64'hDEAD, 31,  0, 0, 0, 4'b0110, 3);
    tab[5] = mk(1, 0, 0, 0, 4'b0000, 64'h100,   5, 1, 0, 1, 4'hA, 1, 1, 1, 64'h100,   5,  1, 1, 0, 4'b0110, 4);
    tab[6] = mk(1, 0, 0, 1, 4'b1000, 64'h200,   6, 0, 1, 0, 4'hB, 0, 1, 1, 64'h100,   5,  1, 1, 0, 4'b0110, 4);
    tab[7] = mk(0, 1, 0, 0, 4'b0000, 64'h0,     0, 0, 0, 0, 4'hE, 1, 1, 0, 64'h100,   5,  1, 1, 0, 4'b0110, 4);
    tab[8] = mk(0, 0, 0, 0, 4'b0000, 64'h0,     0, 0, 0, 0, 4'hC, 1, 0, 0, 64'h100,   5,  1, 1, 0, 4'b0110, 4);

    idle_inputs();
    bus4.in_valid = 0; bus4.alu_result = 0; bus4.alu_negative = 0; bus4.alu_zero = 0;
    bus4.alu_overflow = 0; bus4.alu_carry_out = 0; bus4.set_flags = 0; bus4.store_data = 0;
    bus4.rd = 0; bus4.mem_read = 0; bus4.mem_write = 0; bus4.reg_write = 0; bus4.cond = 0;
    bus4.flush = 0; bus4.out_ready = 0;
    rst_n = 0; rst4_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset flags", 64'(bus.flags), 64'd0);
    chk("reset accept_count", 64'(bus.accept_count), 64'd0);
    #3 rst_n = 1; rst4_n = 1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      bus.in_valid = tab[i].iv; bus.out_ready = tab[i].ordy; bus.flush = tab[i].fl;
      bus.set_flags = tab[i].sf;
      {bus.alu_negative, bus.alu_zero, bus.alu_carry_out, bus.alu_overflow} = tab[i].nzcv;
      bus.alu_result = tab[i].res; bus.store_data = ~tab[i].res; bus.rd = tab[i].rd;
      bus.mem_read = tab[i].mr; bus.mem_write = tab[i].mw; bus.reg_write = tab[i].rw;
      bus.cond = tab[i].cc;
      pre_edge();
      chk($sformatf("vec%0d in_ready", i), 64'(bus.in_ready), 64'(tab[i].e_ready));
      chk($sformatf("vec%0d cond_true", i), 64'(bus.cond_true), 64'(tab[i].e_ct));
      post_edge();
      chk($sformatf("vec%0d out_valid", i), 64'(bus.out_valid), 64'(tab[i].e_valid));
      chk($sformatf("vec%0d out_result", i), bus.out_result, tab[i].e_res);
      chk($sformatf("vec%0d out_rd", i), 64'(bus.out_rd), 64'(tab[i].e_rd));
      chk($sformatf("vec%0d ctl", i), 64'({bus.out_reg_write, bus.out_mem_read, bus.out_mem_write}),
          64'({tab[i].e_rw, tab[i].e_mr, tab[i].e_mw}));
      chk($sformatf("vec%0d flags", i), 64'(bus.flags), 64'(tab[i].e_flags));
      chk($sformatf("vec%0d accept_count", i), 64'(bus.accept_count), 64'(tab[i].e_cnt));
    end

    // Backpressure: held entry stays put for 3 cycles, then the next one loads with no bubble.
    idle_inputs();
    bus.in_valid = 1; bus.alu_result = 64'hA1; bus.rd = 1; bus.reg_write = 1;
    pre_edge(); post_edge();
    bus.alu_result = 64'hB2; bus.rd = 2;
    for (int k = 0; k < 3; k++) begin
      pre_edge();
      chk("stall in_ready", 64'(bus.in_ready), 64'd0);
      post_edge();
      chk("stall out_result", bus.out_result, 64'hA1);
    end
    bus.out_ready = 1;
    pre_edge();
    chk("release in_ready", 64'(bus.in_ready), 64'd1);
    post_edge();
    chk("release out_valid", 64'(bus.out_valid), 64'd1);
    chk("release out_result", bus.out_result, 64'hB2);
    bus.in_valid = 0;
    pre_edge(); post_edge();

    // Randomized traffic against the model.
    for (int k = 0; k < 300; k++) begin
      bus.in_valid      = ($urandom_range(0, 3) != 0);
      bus.out_ready     = $urandom_range(0, 1);
      bus.flush         = ($urandom_range(0, 7) == 0);
      bus.set_flags     = $urandom_range(0, 1);
      bus.alu_negative  = $urandom_range(0, 1);
      bus.alu_zero      = $urandom_range(0, 1);
      bus.alu_carry_out = $urandom_range(0, 1);
      bus.alu_overflow  = $urandom_range(0, 1);
      bus.alu_result    = {$urandom, $urandom};
      bus.store_data    = {$urandom, $urandom};
      bus.rd            = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      bus.mem_read      = $urandom_range(0, 1);
      bus.mem_write     = $urandom_range(0, 1);
      bus.reg_write     = $urandom_range(0, 1);
      bus.cond          = 4'($urandom_range(0, 15));
      pre_edge(); post_edge();
    end

    // Reset in the middle of a stalled transfer with a pending flag update.
    idle_inputs();
    bus.in_valid = 1; bus.set_flags = 1; bus.alu_negative = 1; bus.alu_result = 64'h77;
    pre_edge(); post_edge();
    #2 rst_n = 0;
    #1;
    chk("midreset out_valid", 64'(bus.out_valid), 64'd0);
    chk("midreset out_result", bus.out_result, 64'd0);
    chk("midreset flags", 64'(bus.flags), 64'd0);
    chk("midreset accept_count", 64'(bus.accept_count), 64'd0);
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("post-reset in_ready", 64'(bus.in_ready), 64'd1);
    chk("post-reset out_valid", 64'(bus.out_valid), 64'd0);

    // Narrow counter saturates and async reset clears it before the next edge.
    bus4.in_valid = 1; bus4.out_ready = 1; bus4.alu_result = 64'h33; bus4.rd = 7;
    bus4.reg_write = 1; bus4.set_flags = 1; bus4.alu_zero = 1;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk);
      #1;
      if (k == 15) chk("cnt4 at 15", 64'(bus4.accept_count), 64'hF);
    end
    chk("cnt4 saturated", 64'(bus4.accept_count), 64'hF);
    chk("cnt4 out_valid", 64'(bus4.out_valid), 64'd1);
    bus4.in_valid = 0;
    #2 rst4_n = 0;
    #1;
    chk("cnt4 reset count", 64'(bus4.accept_count), 64'd0);
    chk("cnt4 reset out_valid", 64'(bus4.out_valid), 64'd0);
    chk("cnt4 reset data", bus4.out_result | 64'(bus4.out_rd) | 64'(bus4.out_reg_write), 64'd0);
    chk("cnt4 reset flags", 64'(bus4.flags), 64'd0);
    rst4_n = 1;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/alu_ex_mem_stage.md
ALU_EX_MEM_STAGE -- requirements
Module: alu_ex_mem_stage

Interface
REQ-001 Parameter CNT_W, default 32: width of the accepted-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  EX instruction present.
REQ-005 in_ready  output  1  stage can accept this cycle.
REQ-006 alu_result  input  64  ALU result.
REQ-007 alu_negative, alu_zero, alu_overflow, alu_carry_out  input  1 each  ALU flags.
REQ-008 set_flags  input  1  instruction writes NZCV (ADDS/SUBS).
REQ-009 store_data  input  64  STUR data.
REQ-010 rd  input  5  destination register.
REQ-011 mem_read, mem_write, reg_write  input  1 each  control bits.
REQ-012 cond  input  4  B.cond condition code of the EX instruction.
REQ-013 flush  input  1  squash the pipeline register.
REQ-014 out_ready  input  1  MEM stage accepts.
REQ-015 out_valid  output  1  MEM-side entry valid.
REQ-016 out_result, out_store_data  output  64 each  registered copies.
REQ-017 out_rd  output  5; out_mem_read, out_mem_write, out_reg_write  output  1 each.
REQ-018 flags  output  4  architectural {N,Z,C,V} register.
REQ-019 cond_true  output  1  combinational B.cond outcome.
REQ-020 accept_count  output  CNT_W  instructions accepted since reset.

Function
REQ-021 Single-entry register; in_ready SHALL equal (!out_valid | out_ready).
REQ-022 Accept = in_valid & in_ready & !flush; on accept, all out_* SHALL load from inputs next edge, out_valid=1; latency exactly 1 cycle.
REQ-023 out_valid & out_ready & no accept SHALL clear out_valid next edge.
REQ-024 out_valid & !out_ready SHALL hold every out_* stable; in_ready=0.
REQ-025 Simultaneous drain and accept SHALL load new entry, out_valid stays 1 (no bubble).
REQ-026 rd==31 (XZR) SHALL register out_reg_write=0 regardless of reg_write.
REQ-027 mem_read & mem_write both 1 SHALL register both as 0 (illegal combination dropped).
REQ-028 flags SHALL load {alu_negative,alu_zero,alu_carry_out,alu_overflow} only on accept with set_flags=1; otherwise hold.
REQ-029 Flush SHALL clear out_valid next edge, block accept, block flag update, block counter increment; flush dominates every other event.
REQ-030 cond_true SHALL evaluate against forwarded flags: ALU flags when in_valid & set_flags, else flags register.
REQ-031 Codes: 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E,F always 1.
REQ-032 accept_count SHALL increment by 1 per accept and saturate at all-ones (no wrap).
REQ-033 Outputs other than in_ready and cond_true SHALL be registered only.

Reset
REQ-034 rst_n low SHALL immediately clear out_valid, all out_* data/control, flags (4'b0000), accept_count.
REQ-035 Reset asserted mid-transfer SHALL discard the entry; no flag update survives.
REQ-036 After rst_n rises, in_ready=1 and first accept occurs no earlier than the next edge.

Verification
REQ-037 Accept alu_result=64'h5, rd=3, reg_write=1, out_ready=1 -> next cycle out_valid=1, out_result=5, out_rd=3, out_reg_write=1; accept_count=1.
REQ-038 out_ready=0 with held entry, new in_valid=1 -> in_ready=0, out_result unchanged for 3 cycles; release out_ready -> new entry loads, no bubble.
REQ-039 SUBS with alu_zero=1, alu_carry_out=1, set_flags=1, cond=0 -> cond_true=1 same cycle; next cycle flags=4'b0110.
REQ-040 Accept with set_flags=1 and flush=1 same cycle -> out_valid=0, flags unchanged, accept_count unchanged.
REQ-041 rd=31, reg_write=1 -> out_reg_write=0; mem_read=mem_write=1 -> both outputs 0.
REQ-042 CNT_W=4, 17 accepts -> accept_count=4'hF; async rst_n pulse mid-cycle -> all outputs 0 before next edge.
